gpio_serial_loader: RTL and testbench



---
 rtl/gpio_serial_loader_pkg.sv | 23 ++
 rtl/gpio_serial_phase_timer.sv | 28 ++
 rtl/gpio_serial_loader.sv | 150 +++++++++++++++
 tb/tb_gpio_serial_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_serial_loader_pkg.sv
// Shared definitions for the GPIO configuration shift chain: per-block bit layout and
// loader FSM state encoding, kept here so software headers and the RTL agree.
package gpio_serial_loader_pkg;

    // Bit offsets inside one PAD_CTRL_BITS-wide control block word.
    localparam int unsigned MGMT_EN     = 0;
    localparam int unsigned OE_OVR      = 1;
    localparam int unsigned IE          = 2;
    localparam int unsigned OE          = 3;
    localparam int unsigned SCHMITT     = 4;
    localparam int unsigned SLEW        = 5;
    localparam int unsigned PD          = 6;
    localparam int unsigned PU          = 7;
    localparam int unsigned DRIVE_LSB   = 8;
    localparam int unsigned DRIVE_MSB   = 9;
    localparam int unsigned DRIVE_WIDTH = DRIVE_MSB - DRIVE_LSB + 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT_LO = 2'd1;
    localparam logic [1:0] ST_SHIFT_HI = 2'd2;
    localparam logic [1:0] ST_LOAD     = 2'd3;

endpackage

// File: rtl/gpio_serial_phase_timer.sv
// Down-counter that times one serial_clock phase; restarted by the FSM on every phase entry.
module gpio_serial_phase_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic phase_end
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 8'd1;
        end
    end

    // High in the last cycle of a phase; the FSM only looks at it outside IDLE.
    assign phase_end = (count == '0);

endmodule

// File: rtl/gpio_serial_loader.sv
// Stores one configuration word per GPIO and serially shifts the whole set into the
// padframe control-block chain, finishing with a load strobe.
module gpio_serial_loader
    import gpio_serial_loader_pkg::*;
#(
    parameter int unsigned NUM_IO                  = 38,
    parameter int unsigned PAD_CTRL_BITS           = 10,
    parameter int unsigned CLK_DIV                 = 4,
    parameter logic [PAD_CTRL_BITS-1:0] CFG_RESET  = PAD_CTRL_BITS'(3)
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       cfg_wr_en,
    input  logic [$clog2(NUM_IO)-1:0]  cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0]   cfg_wr_data,
    output logic [PAD_CTRL_BITS-1:0]   cfg_rd_data,
    output logic                       cfg_wr_ack,
    input  logic                       xfer_start,
    output logic                       busy,
    output logic                       done,
    output logic                       serial_clock,
    output logic                       serial_data_out,
    output logic                       serial_load,
    output logic                       serial_resetn
);

    localparam int unsigned TOTAL_BITS = NUM_IO * PAD_CTRL_BITS;
    localparam int unsigned BW         = $clog2(TOTAL_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(TOTAL_BITS - 1);

    logic [PAD_CTRL_BITS-1:0] cfg_mem [NUM_IO];
    logic [TOTAL_BITS-1:0]    send_vec;
    logic [1:0]               state;
    logic [BW-1:0]            bit_cnt;
    logic [BW-1:0]            next_idx;
    logic                     next_bit;
    logic                     addr_ok;
    logic                     wr_ok;
    logic                     timer_start;
    logic                     phase_end;

    assign addr_ok     = 32'(cfg_addr) < NUM_IO;
    assign wr_ok       = cfg_wr_en && addr_ok && (state == ST_IDLE);
    assign cfg_rd_data = addr_ok ? cfg_mem[cfg_addr] : '0;

    // send_vec[k] is the k-th bit on the wire: highest GPIO first, MSB first in each word.
    always_comb begin
        send_vec = '0;
        for (int unsigned g = 0; g < NUM_IO; g++) begin
            for (int unsigned b = 0; b < PAD_CTRL_BITS; b++) begin
                send_vec[(NUM_IO - 1 - g) * PAD_CTRL_BITS + (PAD_CTRL_BITS - 1 - b)] =
                    cfg_mem[g][b];
            end
        end
    end

    assign next_idx = (state == ST_IDLE) ? '0 : bit_cnt + 1'b1;
    assign next_bit = send_vec[next_idx];

    always_comb begin
        timer_start = 1'b0;
        case (state)
            ST_IDLE:     timer_start = xfer_start;
            ST_SHIFT_LO: timer_start = phase_end;
            ST_SHIFT_HI: timer_start = phase_end;
            default:     timer_start = 1'b0;
        endcase
    end

    gpio_serial_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .start     (timer_start),
        .phase_end (phase_end)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state           <= ST_IDLE;
            bit_cnt         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_wr_ack      <= 1'b0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                cfg_mem[i] <= CFG_RESET;
            end
        end else begin
            done       <= 1'b0;
            cfg_wr_ack <= wr_ok;
            if (wr_ok) begin
                cfg_mem[cfg_addr] <= cfg_wr_data;
            end
            case (state)
                ST_IDLE: begin
                    if (xfer_start) begin
                        state           <= ST_SHIFT_LO;
                        busy            <= 1'b1;
                        serial_clock    <= 1'b0;
                        serial_data_out <= next_bit;
                        bit_cnt         <= '0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        state        <= ST_SHIFT_HI;
                        serial_clock <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        serial_clock <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state           <= ST_LOAD;
                            serial_data_out <= 1'b0;
                            serial_load     <= 1'b1;
                        end else begin
                            state           <= ST_SHIFT_LO;
                            bit_cnt         <= next_idx;
                            serial_data_out <= next_bit;
                        end
                    end
                end
                ST_LOAD: begin
                    if (phase_end) begin
                        state       <= ST_IDLE;
                        serial_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Chain reset is released on the first clock after wb_rst_i drops.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            serial_resetn <= 1'b0;
        end else begin
            serial_resetn <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader with two chained control blocks modelled behaviourally;
// stimulus queues expected results, a negedge monitor compares them when the DUT responds.
module tb_gpio_serial_loader;

    localparam int unsigned NIO = 2;
    localparam int unsigned PCB = 10;
    localparam int unsigned CD  = 2;
    localparam int unsigned T   = 20;
    localparam int unsigned LAT = 83;

    logic       wb_clk_i    = 1'b0;
    logic       wb_rst_i    = 1'b1;
    logic       cfg_wr_en   = 1'b0;
    logic [0:0] cfg_addr    = 1'b0;
    logic [9:0] cfg_wr_data = '0;
    logic       xfer_start  = 1'b0;
    logic [9:0] cfg_rd_data;
    logic       cfg_wr_ack, busy, done;
    logic       serial_clock, serial_data_out, serial_load, serial_resetn;

    gpio_serial_loader #(
        .NUM_IO        (NIO),
        .PAD_CTRL_BITS (PCB),
        .CLK_DIV       (CD),
        .CFG_RESET     (10'h003)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_addr        (cfg_addr),
        .cfg_wr_data     (cfg_wr_data),
        .cfg_rd_data     (cfg_rd_data),
        .cfg_wr_ack      (cfg_wr_ack),
        .xfer_start      (xfer_start),
        .busy            (busy),
        .done            (done),
        .serial_clock    (serial_clock),
        .serial_data_out (serial_data_out),
        .serial_load     (serial_load),
        .serial_resetn   (serial_resetn)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Two chained control blocks: block 0 sits nearest the loader.
    logic [9:0] m_sr0  = '0;
    logic [9:0] m_sr1  = '0;
    logic [9:0] m_lat0 = 10'h003;
    logic [9:0] m_lat1 = 10'h003;

    always @(posedge serial_clock or negedge serial_resetn) begin
        if (!serial_resetn) begin
            m_sr0 <= '0;
            m_sr1 <= '0;
        end else begin
            m_sr0 <= {m_sr0[8:0], serial_data_out};
            m_sr1 <= {m_sr1[8:0], m_sr0[9]};
        end
    end

    always @(posedge serial_load or negedge serial_resetn) begin
        if (!serial_resetn) begin
            m_lat0 <= 10'h003;
            m_lat1 <= 10'h003;
        end else begin
            m_lat0 <= m_sr0;
            m_lat1 <= m_sr1;
        end
    end

    typedef struct {
        logic [9:0] g1;
        logic [9:0] g0;
        int         hi;
    } xfer_t;

    xfer_t xq[$];
    int    ackq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    logic        prev_sclk = 0, prev_load = 0, prev_sdo = 0, prev_busy = 0;
    int          rises_all = 0, rises = 0, loads = 0, hi_cycles = 0, viol = 0, dones = 0;
    int          t_start = 0;
    logic [19:0] bits = '0;

    initial forever begin
        @(negedge wb_clk_i);
        if (wb_rst_i) begin
            prev_sclk = 0; prev_load = 0; prev_sdo = 0; prev_busy = 0;
            continue;
        end
        if (busy && !prev_busy) begin
            rises = 0; loads = 0; hi_cycles = 0; viol = 0; bits = '0; t_start = cyc;
        end
        if (serial_clock && !prev_sclk) begin
            rises++;
            rises_all++;
            bits = {bits[18:0], serial_data_out};
        end
        if (serial_clock && (serial_data_out != prev_sdo)) viol++;
        if (serial_load && !prev_load) begin
            loads++;
            if (serial_clock || rises != int'(T)) viol++;
        end
        if (busy && serial_data_out) hi_cycles++;
        if (cfg_wr_ack) begin
            if (ackq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected cfg_wr_ack: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                check("ack cycle", 32'(cyc), 32'(ackq.pop_front()));
            end
        end
        if (done) begin
            dones++;
            if (xq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected done: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                xfer_t e;
                e = xq.pop_front();
                // Latency counts to the clock edge that samples done high.
                check("done latency", 32'(cyc - t_start + 1), 32'(LAT));
                check("sclk rises", 32'(rises), 32'(T));
                check("load rises", 32'(loads), 32'd1);
                check("bit stream", 32'(bits), 32'({e.g1, e.g0}));
                check("sdo high cycles", 32'(hi_cycles), 32'(e.hi));
                check("timing violations", 32'(viol), 32'd0);
                check("model gpio0", 32'(m_lat0), 32'(e.g0));
                check("model gpio1", 32'(m_lat1), 32'(e.g1));
                check("busy at done", 32'(busy), 32'd0);
            end
        end
        prev_sclk = serial_clock;
        prev_load = serial_load;
        prev_sdo  = serial_data_out;
        prev_busy = busy;
    end

    task automatic wr(input logic a, input logic [9:0] d, input bit exp_ack);
        @(negedge wb_clk_i);
        cfg_wr_en   = 1'b1;
        cfg_addr    = a;
        cfg_wr_data = d;
        if (exp_ack) ackq.push_back(cyc + 1);
        @(negedge wb_clk_i);
        cfg_wr_en = 1'b0;
    endtask

    task automatic start(input logic [9:0] g1, input logic [9:0] g0, input int hi,
                         input bit exp_done);
        xfer_t e;
        @(negedge wb_clk_i);
        xfer_start = 1'b1;
        if (exp_done) begin
            e.g1 = g1; e.g0 = g0; e.hi = hi;
            xq.push_back(e);
        end
        @(negedge wb_clk_i);
        xfer_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge wb_clk_i);
            #1;
            if (xq.size() == 0 && !busy) break;
        end
        check({name, " completed"}, 32'(xq.size()), 32'd0);
        xq.delete();
    endtask

    task automatic rd(input logic a, input logic [9:0] exp, input string name);
        cfg_addr = a;
        #1;
        check(name, 32'(cfg_rd_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // Reset
        repeat (3) @(negedge wb_clk_i);
        check("rst serial_resetn", 32'(serial_resetn), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sclk", 32'(serial_clock), 32'd0);
        check("rst sload", 32'(serial_load), 32'd0);
        check("rst sdo", 32'(serial_data_out), 32'd0);
        check("rst ack", 32'(cfg_wr_ack), 32'd0);
        wb_rst_i = 1'b0;
        #1;
        check("resetn before edge", 32'(serial_resetn), 32'd0);
        @(posedge wb_clk_i);
        #1;
        check("resetn after release", 32'(serial_resetn), 32'd1);
        rd(1'b0, 10'h003, "reset word gpio0");
        rd(1'b1, 10'h003, "reset word gpio1");
        repeat (5) @(negedge wb_clk_i);
        check("no sclk after reset", 32'(rises_all), 32'd0);

        // Basic transfer: 5 + 5 ones, 4 cycles each
        wr(1'b0, 10'h155, 1'b1);
        wr(1'b1, 10'h2AA, 1'b1);
        rd(1'b0, 10'h155, "readback gpio0");
        rd(1'b1, 10'h2AA, "readback gpio1");
        start(10'h2AA, 10'h155, 40, 1'b1);
        wait_idle("basic xfer");

        // Bit order plus busy rules: only the very first bit is 1
        wr(1'b1, 10'h200, 1'b1);
        wr(1'b0, 10'h000, 1'b1);
        d0 = dones;
        start(10'h200, 10'h000, 4, 1'b1);
        repeat (10) @(negedge wb_clk_i);
        wr(1'b0, 10'h3FF, 1'b0);
        start(10'h000, 10'h000, 0, 1'b0);
        wait_idle("bit order xfer");
        repeat (120) @(negedge wb_clk_i);
        check("single done", 32'(dones - d0), 32'd1);
        rd(1'b0, 10'h000, "busy write dropped");

        // Reset mid-shift after 7 bits
        start(10'h000, 10'h000, 0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk_i);
            #1;
            if (rises >= 7) break;
        end
        check("reached 7 bits", 32'(rises >= 7), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check("abort sclk", 32'(serial_clock), 32'd0);
        check("abort sload", 32'(serial_load), 32'd0);
        check("abort resetn", 32'(serial_resetn), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort sdo", 32'(serial_data_out), 32'd0);
        check("model sr cleared", 32'({m_sr1, m_sr0}), 32'd0);
        check("model lat0 default", 32'(m_lat0), 32'h003);
        check("model lat1 default", 32'(m_lat1), 32'h003);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check("resetn after abort", 32'(serial_resetn), 32'd1);
        rd(1'b0, 10'h003, "post-abort gpio0");
        rd(1'b1, 10'h003, "post-abort gpio1");

        // Transfer after abort: 4 + 4 ones
        wr(1'b0, 10'h0F0, 1'b1);
        wr(1'b1, 10'h30C, 1'b1);
        start(10'h30C, 10'h0F0, 32, 1'b1);
        wait_idle("post-abort xfer");

        repeat (5) @(negedge wb_clk_i);
        check("pending acks", 32'(ackq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
